// File: rtl/gth_pattern_pkg.sv
// Shared definitions for the GTH user-data pattern generator / checker lanes.
package gth_pattern_pkg;

  // Per-channel mode encoding as carried on mode_in.
  typedef enum logic [1:0] {
    MODE_OFF     = 2'b00,
    MODE_COUNTER = 2'b01,
    MODE_PRBS31  = 2'b10,
    MODE_FIXED   = 2'b11
  } mode_e;

  // Loopback checker states.
  typedef enum logic [1:0] {
    CHK_SEEK,
    CHK_VERIFY,
    CHK_LOCKED
  } chk_state_e;

  localparam logic [30:0] PRBS31_SEED = 31'h7FFF_FFFF;

  // The step function works on byte-sized chunks; lanes chain DATA_W/8 calls.
  localparam int unsigned PRBS_CHUNK_W = 8;

  typedef struct packed {
    logic [30:0]             state;
    logic [PRBS_CHUNK_W-1:0] word;
  } prbs_step_t;

  // x^31 + x^28 + 1, Fibonacci form. state[0] is the newest bit; word bit 0 is
  // generated first. Advances min(nbits, PRBS_CHUNK_W) bits.
  function automatic prbs_step_t prbs31_step(input logic [30:0] state,
                                             input int unsigned nbits);
    prbs_step_t r;
    logic       fb;
    r.state = state;
    r.word  = '0;
    for (int unsigned i = 0; i < PRBS_CHUNK_W; i++) begin
      if (i < nbits) begin
        fb        = r.state[30] ^ r.state[27];
        r.word[i] = fb;
        r.state   = {r.state[29:0], fb};
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/gth_pattern_lanes_lane.sv
// One channel: pattern generator for TX user data plus a self-seeding
// loopback checker with lock tracking and a saturating error counter.
module gth_pattern_lane
  import gth_pattern_pkg::*;
#(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned CNT_W      = 32,
  parameter int unsigned LOCK_CNT   = 16,
  parameter int unsigned UNLOCK_ERR = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              tx_active_i,
  input  logic [1:0]        mode_i,
  input  logic [DATA_W-1:0] fixed_pattern_i,
  input  logic              err_inject_i,
  output logic [DATA_W-1:0] data_o,
  input  logic [DATA_W-1:0] rx_data_i,
  input  logic              rx_valid_i,
  input  logic              clear_i,
  output logic              locked_o,
  output logic [CNT_W-1:0]  err_cnt_o
);

  localparam int unsigned GOOD_W = $clog2(LOCK_CNT + 1);
  localparam int unsigned BAD_W  = $clog2(UNLOCK_ERR + 1);
  localparam logic [GOOD_W-1:0] GOOD_LAST = GOOD_W'(LOCK_CNT);
  localparam logic [BAD_W-1:0]  BAD_LAST  = BAD_W'(UNLOCK_ERR);

  mode_e             mode_q, mode_new;
  logic              mode_chg;
  logic [DATA_W-1:0] cnt_q, cnt_d, data_q, data_d;
  logic [30:0]       lfsr_q, lfsr_d, gen_lfsr_nx;
  logic [DATA_W-1:0] gen_word;
  prbs_step_t        gen_chunk;
  logic              inj_q, inj_d;

  chk_state_e        st_q, st_d;
  logic [DATA_W-1:0] exp_cnt_q, exp_cnt_d, exp_word, chk_word;
  logic [30:0]       pred_q, pred_d, chk_lfsr_nx, seed_lfsr;
  prbs_step_t        chk_chunk;
  logic [GOOD_W-1:0] good_q, good_d;
  logic [BAD_W-1:0]  bad_q, bad_d;
  logic [CNT_W-1:0]  err_q, err_d;
  logic              match;

  assign mode_new = mode_e'(mode_i);
  assign mode_chg = (mode_new != mode_q);

  // Generator PRBS: next DATA_W-bit word and state from the TX LFSR.
  always_comb begin
    gen_lfsr_nx = lfsr_q;
    gen_word    = '0;
    gen_chunk   = '0;
    for (int unsigned b = 0; b < DATA_W / PRBS_CHUNK_W; b++) begin
      gen_chunk = prbs31_step(gen_lfsr_nx, PRBS_CHUNK_W);
      gen_word[b*PRBS_CHUNK_W +: PRBS_CHUNK_W] = gen_chunk.word;
      gen_lfsr_nx = gen_chunk.state;
    end
  end

  // Generator next state; an inject pulse seen while idle waits for the next word.
  always_comb begin
    cnt_d  = cnt_q;
    lfsr_d = lfsr_q;
    data_d = data_q;
    inj_d  = inj_q | err_inject_i;
    if (mode_chg) begin
      cnt_d  = '0;
      lfsr_d = PRBS31_SEED;
    end else if (tx_active_i) begin
      case (mode_q)
        MODE_COUNTER: begin
          data_d = cnt_q;
          cnt_d  = cnt_q + DATA_W'(1);
        end
        MODE_PRBS31: begin
          data_d = gen_word;
          lfsr_d = gen_lfsr_nx;
        end
        MODE_FIXED: data_d = fixed_pattern_i;
        default:    data_d = '0;
      endcase
      data_d[0] = data_d[0] ^ inj_d;
      inj_d     = 1'b0;
    end
  end

  // Checker PRBS: expected word and next predictor state.
  always_comb begin
    chk_lfsr_nx = pred_q;
    chk_word    = '0;
    chk_chunk   = '0;
    for (int unsigned b = 0; b < DATA_W / PRBS_CHUNK_W; b++) begin
      chk_chunk = prbs31_step(chk_lfsr_nx, PRBS_CHUNK_W);
      chk_word[b*PRBS_CHUNK_W +: PRBS_CHUNK_W] = chk_chunk.word;
      chk_lfsr_nx = chk_chunk.state;
    end
  end

  // Expected word per mode, and LFSR seed from the newest 31 received bits.
  always_comb begin
    case (mode_q)
      MODE_COUNTER: exp_word = exp_cnt_q;
      MODE_PRBS31:  exp_word = chk_word;
      MODE_FIXED:   exp_word = fixed_pattern_i;
      default:      exp_word = '0;
    endcase
    match     = (rx_data_i == exp_word);
    seed_lfsr = '0;
    for (int unsigned i = 0; i < 31; i++) begin
      seed_lfsr[i] = rx_data_i[DATA_W-1-i];
    end
  end

  // Checker FSM; the predictor always advances from its own expectation.
  always_comb begin
    st_d      = st_q;
    exp_cnt_d = exp_cnt_q;
    pred_d    = pred_q;
    good_d    = good_q;
    bad_d     = bad_q;
    err_d     = err_q;
    if (mode_chg || (mode_q == MODE_OFF)) begin
      st_d = CHK_SEEK;
    end else if (rx_valid_i) begin
      case (st_q)
        CHK_SEEK: begin
          exp_cnt_d = rx_data_i + DATA_W'(1);
          pred_d    = seed_lfsr;
          good_d    = '0;
          st_d      = CHK_VERIFY;
        end
        CHK_VERIFY: begin
          exp_cnt_d = exp_cnt_q + DATA_W'(1);
          pred_d    = chk_lfsr_nx;
          if (match) begin
            good_d = good_q + GOOD_W'(1);
            if (good_d == GOOD_LAST) begin
              bad_d = '0;
              st_d  = CHK_LOCKED;
            end
          end else begin
            st_d = CHK_SEEK;
          end
        end
        CHK_LOCKED: begin
          exp_cnt_d = exp_cnt_q + DATA_W'(1);
          pred_d    = chk_lfsr_nx;
          if (match) begin
            bad_d = '0;
          end else begin
            if (err_q != '1) err_d = err_q + CNT_W'(1);
            bad_d = bad_q + BAD_W'(1);
            if (bad_d == BAD_LAST) st_d = CHK_SEEK;
          end
        end
        default: st_d = CHK_SEEK;
      endcase
    end
    if (clear_i) err_d = '0;
  end

  // State registers for generator and checker.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mode_q    <= MODE_OFF;
      cnt_q     <= '0;
      lfsr_q    <= PRBS31_SEED;
      data_q    <= '0;
      inj_q     <= 1'b0;
      st_q      <= CHK_SEEK;
      exp_cnt_q <= '0;
      pred_q    <= PRBS31_SEED;
      good_q    <= '0;
      bad_q     <= '0;
      err_q     <= '0;
    end else begin
      mode_q    <= mode_new;
      cnt_q     <= cnt_d;
      lfsr_q    <= lfsr_d;
      data_q    <= data_d;
      inj_q     <= inj_d;
      st_q      <= st_d;
      exp_cnt_q <= exp_cnt_d;
      pred_q    <= pred_d;
      good_q    <= good_d;
      bad_q     <= bad_d;
      err_q     <= err_d;
    end
  end

  assign data_o    = data_q;
  assign locked_o  = (st_q == CHK_LOCKED);
  assign err_cnt_o = err_q;

endmodule

// File: rtl/gth_pattern_lanes.sv
// Multi-channel GTH user-data pattern generator / loopback checker.
module gth_pattern_lanes
  import gth_pattern_pkg::*;
#(
  parameter int unsigned NUM_CH     = 2,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned CNT_W      = 32,
  parameter int unsigned LOCK_CNT   = 16,
  parameter int unsigned UNLOCK_ERR = 4
) (
  input  logic                     clk_in,
  input  logic                     reset_in,
  input  logic [NUM_CH-1:0]        tx_active_in,
  input  logic [2*NUM_CH-1:0]      mode_in,
  input  logic [DATA_W-1:0]        fixed_pattern_in,
  input  logic [NUM_CH-1:0]        err_inject_in,
  output logic [NUM_CH*DATA_W-1:0] data_out,
  input  logic [NUM_CH*DATA_W-1:0] rx_data_in,
  input  logic [NUM_CH-1:0]        rx_valid_in,
  input  logic                     clear_in,
  output logic [NUM_CH-1:0]        locked_out,
  output logic [NUM_CH*CNT_W-1:0]  err_cnt_out
);

  for (genvar k = 0; k < NUM_CH; k++) begin : g_lane
    gth_pattern_lane #(
      .DATA_W     (DATA_W),
      .CNT_W      (CNT_W),
      .LOCK_CNT   (LOCK_CNT),
      .UNLOCK_ERR (UNLOCK_ERR)
    ) u_lane (
      .clk_i           (clk_in),
      .rst_i           (reset_in),
      .tx_active_i     (tx_active_in[k]),
      .mode_i          (mode_in[2*k +: 2]),
      .fixed_pattern_i (fixed_pattern_in),
      .err_inject_i    (err_inject_in[k]),
      .data_o          (data_out[k*DATA_W +: DATA_W]),
      .rx_data_i       (rx_data_in[k*DATA_W +: DATA_W]),
      .rx_valid_i      (rx_valid_in[k]),
      .clear_i         (clear_in),
      .locked_o        (locked_out[k]),
      .err_cnt_o       (err_cnt_out[k*CNT_W +: CNT_W])
    );
  end

endmodule

// File: tb/tb_gth_pattern_lanes.sv
// Loopback bench for gth_pattern_lanes: directed stimulus pushes expectations
// into a cycle-tagged queue, a negedge monitor pops and compares.
module tb_gth_pattern_lanes;

  localparam int DW = 32;
  localparam int CW = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [1:0]  tx_active = '0;
  logic [3:0]  mode = '0;
  logic [31:0] fixed = '0;
  logic [1:0]  inj = '0;
  logic [63:0] data_out;
  logic [63:0] rx_data;
  logic [1:0]  rx_valid = '0;
  logic        clear = 1'b0;
  logic [1:0]  locked;
  logic [7:0]  err_cnt;

  always #5 clk = ~clk;

  assign rx_data = data_out;

  gth_pattern_lanes #(
    .NUM_CH (2),
    .DATA_W (DW),
    .CNT_W  (CW)
  ) dut (
    .clk_in           (clk),
    .reset_in         (rst),
    .tx_active_in     (tx_active),
    .mode_in          (mode),
    .fixed_pattern_in (fixed),
    .err_inject_in    (inj),
    .data_out         (data_out),
    .rx_data_in       (rx_data),
    .rx_valid_in      (rx_valid),
    .clear_in         (clear),
    .locked_out       (locked),
    .err_cnt_out      (err_cnt)
  );

  localparam int K_DATA = 0, K_LOCK = 1, K_ERR = 2;

  typedef struct {
    int          cyc;
    int          kind;
    int          ch;
    logic [31:0] val;
    string       name;
  } exp_t;

  exp_t sbq[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // PRBS31 reference: b[n] = b[n-31] ^ b[n-28], 31 leading ones as the seed.
  localparam int NWORDS = 64;
  bit pb [0:31+32*NWORDS-1];

  function automatic logic [31:0] ref_word(input int w);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = pb[31 + 32*w + i];
    return r;
  endfunction

  function automatic logic [31:0] observe(input int kind, input int ch);
    case (kind)
      K_DATA:  return data_out[ch*32 +: 32];
      K_LOCK:  return {31'b0, locked[ch]};
      default: return {28'b0, err_cnt[ch*CW +: CW]};
    endcase
  endfunction

  task automatic push_exp(input int kind, input int ch, input logic [31:0] v, input string name);
    exp_t e;
    e.cyc = cyc; e.kind = kind; e.ch = ch; e.val = v; e.name = name;
    sbq.push_back(e);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  exp_t        mon_e;
  logic [31:0] mon_act;

  // Monitor: everything scheduled for this cycle is compared at the falling edge.
  always @(negedge clk) begin
    while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
      mon_e   = sbq.pop_front();
      mon_act = observe(mon_e.kind, mon_e.ch);
      n_checks++;
      if (mon_e.cyc < cyc) begin
        n_fail++;
        $display("FAIL %s ch%0d: check for cycle %0d missed (now %0d)", mon_e.name, mon_e.ch, mon_e.cyc, cyc);
      end else if (mon_act !== mon_e.val) begin
        n_fail++;
        $display("FAIL %s ch%0d cyc %0d: got %h expected %h", mon_e.name, mon_e.ch, cyc, mon_act, mon_e.val);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int n = 0; n < 31; n++) pb[n] = 1'b1;
    for (int n = 31; n < 31 + 32*NWORDS; n++) pb[n] = pb[n-31] ^ pb[n-28];

    // Reset state
    #2 rst = 1'b1;
    tick; tick;
    for (int c = 0; c < 2; c++) begin
      push_exp(K_DATA, c, 32'h0, "rst_data");
      push_exp(K_LOCK, c, 32'h0, "rst_lock");
      push_exp(K_ERR,  c, 32'h0, "rst_err");
    end
    tick;

    // COUNTER on channel 0, loopback
    mode = 4'b0001;
    rst  = 1'b0;
    tick;
    tx_active = 2'b01;
    tick;
    push_exp(K_DATA, 0, 32'd0, "cnt_first");
    rx_valid = 2'b01;
    for (int j = 1; j <= 20; j++) begin
      tick;
      push_exp(K_DATA, 0, 32'(j), "cnt_data");
      if (j == 16) push_exp(K_LOCK, 0, 32'h0, "cnt_prelock");
      if (j == 17) push_exp(K_LOCK, 0, 32'h1, "cnt_lock");
    end
    push_exp(K_ERR, 0, 32'h0, "cnt_err");

    // PRBS31 on both channels
    tx_active = 2'b00;
    rx_valid  = 2'b00;
    mode      = 4'b1010;
    tick;
    push_exp(K_LOCK, 0, 32'h0, "prbs_modechg_seek");
    tx_active = 2'b11;
    tick;
    push_exp(K_DATA, 0, 32'h7000_0000, "prbs_first_hand");
    push_exp(K_DATA, 1, ref_word(0), "prbs_first_ref");
    rx_valid = 2'b11;
    for (int j = 1; j <= 20; j++) begin
      tick;
      push_exp(K_DATA, 0, ref_word(j), "prbs_data");
      push_exp(K_DATA, 1, ref_word(j), "prbs_data");
      if (j == 16) begin
        push_exp(K_LOCK, 0, 32'h0, "prbs_prelock");
        push_exp(K_LOCK, 1, 32'h0, "prbs_prelock");
      end
      if (j == 17) begin
        push_exp(K_LOCK, 0, 32'h1, "prbs_lock");
        push_exp(K_LOCK, 1, 32'h1, "prbs_lock");
      end
    end
    push_exp(K_ERR, 0, 32'h0, "prbs_err");
    push_exp(K_ERR, 1, 32'h0, "prbs_err");

    // Isolated injections on channel 1 while locked
    for (int p = 0; p < 3; p++) begin
      inj = 2'b10; tick;
      inj = 2'b00; tick; tick; tick;
    end
    push_exp(K_ERR,  1, 32'd3, "inj3_err");
    push_exp(K_LOCK, 1, 32'h1, "inj3_lock");
    push_exp(K_ERR,  0, 32'd0, "inj3_ch0_err");

    // Four consecutive bad words drop lock
    inj = 2'b10;
    repeat (4) tick;
    inj = 2'b00;
    tick;
    push_exp(K_ERR,  1, 32'd7, "inj4_err");
    push_exp(K_LOCK, 1, 32'h0, "inj4_unlock");
    for (int j = 1; j <= 17; j++) begin
      tick;
      if (j == 16) push_exp(K_LOCK, 1, 32'h0, "relock_pre");
      if (j == 17) begin
        push_exp(K_LOCK, 1, 32'h1, "relock");
        push_exp(K_ERR,  1, 32'd7, "relock_err");
        push_exp(K_LOCK, 0, 32'h1, "relock_ch0");
      end
    end

    // FIXED on channel 0, then switch to PRBS31 mid-stream
    fixed = 32'hA5A5_5A5A;
    mode  = 4'b1011;
    tick;
    for (int j = 1; j <= 17; j++) begin
      tick;
      push_exp(K_DATA, 0, 32'hA5A5_5A5A, "fixed_data");
      if (j == 16) push_exp(K_LOCK, 0, 32'h0, "fixed_prelock");
      if (j == 17) push_exp(K_LOCK, 0, 32'h1, "fixed_lock");
    end
    rx_valid = 2'b10;
    repeat (3) tick;
    push_exp(K_LOCK, 0, 32'h1, "valid_low_hold");
    mode = 4'b1010;
    tick;
    push_exp(K_LOCK, 0, 32'h0, "fix2prbs_seek");
    tick;
    push_exp(K_DATA, 0, 32'h7000_0000, "fix2prbs_restart");
    rx_valid = 2'b11;
    for (int j = 1; j <= 17; j++) begin
      tick;
      push_exp(K_DATA, 0, ref_word(j), "fix2prbs_data");
      if (j == 16) push_exp(K_LOCK, 0, 32'h0, "fix2prbs_prelock");
      if (j == 17) push_exp(K_LOCK, 0, 32'h1, "fix2prbs_lock");
    end

    // Saturation with interleaved good words (count starts at 7, CNT_W=4)
    for (int i = 1; i <= 12; i++) begin
      inj = 2'b10; tick;
      inj = 2'b00; tick;
      if (i == 7)  push_exp(K_ERR, 1, 32'd14, "sat_14");
      if (i == 8)  push_exp(K_ERR, 1, 32'd15, "sat_15");
      if (i == 12) begin
        push_exp(K_ERR,  1, 32'd15, "sat_stick");
        push_exp(K_LOCK, 1, 32'h1,  "sat_lock");
      end
    end
    inj = 2'b10; tick;
    inj = 2'b00; clear = 1'b1; tick;
    clear = 1'b0;
    push_exp(K_ERR, 1, 32'd0, "clear_wins");
    inj = 2'b10; tick;
    inj = 2'b00; tick;
    push_exp(K_ERR, 1, 32'd1, "post_clear_err");

    // Asynchronous reset mid-lock
    push_exp(K_LOCK, 0, 32'h1, "prereset_lock");
    tick;
    rst = 1'b1;
    for (int c = 0; c < 2; c++) begin
      push_exp(K_DATA, c, 32'h0, "async_rst_data");
      push_exp(K_LOCK, c, 32'h0, "async_rst_lock");
      push_exp(K_ERR,  c, 32'h0, "async_rst_err");
    end
    tick;
    mode      = 4'b0001;
    tx_active = 2'b00;
    rx_valid  = 2'b00;
    rst       = 1'b0;
    tick;
    tx_active = 2'b01;
    for (int j = 0; j < 3; j++) begin
      tick;
      push_exp(K_DATA, 0, 32'(j), "restart_cnt");
    end
    push_exp(K_LOCK, 0, 32'h0, "restart_lock");
    push_exp(K_ERR,  1, 32'h0, "restart_err");

    tick; tick;
    n_checks++;
    if (sbq.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sbq.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
